// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM on a shared bidirectional data bus.
// Runs one write or read burst at a time; owns the master side of the bus tri-state.
module ram_burst_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic [2:0]        dbg_state
);

  // Handshakes: a beat/command transfers on a rising edge where valid & ready are both high;
  // rd_valid is a strobe with no backpressure.
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_issue_q, rd_issue_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                wr_ready_q, wr_ready_d;
  logic                ram_ena_q, ram_ena_d;
  logic                ram_wena_q, ram_wena_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    next_addr_d = next_addr_q;
    wdata_d     = wdata_q;
    ram_addr_d  = ram_addr_q;
    ram_ena_d   = 1'b0;
    ram_wena_d  = 1'b0;
    rd_issue_d  = 1'b0;
    // A fresh read address issued in cycle j has its word on the bus in j+1, returned in j+2.
    rd_pend_d   = rd_issue_q;
    rd_valid_d  = rd_pend_q;
    rd_data_d   = rd_pend_q ? ram_data : rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          len_d       = cmd_len;
          cnt_d       = '0;
          next_addr_d = cmd_addr;
          if (cmd_len == '0) begin
            state_d = S_DONE;
          end else if (cmd_write) begin
            state_d = S_WRITE;
          end else begin
            state_d     = S_READ;
            ram_ena_d   = 1'b1;
            ram_addr_d  = cmd_addr;
            next_addr_d = cmd_addr + 1'b1;
            cnt_d       = LEN_W'(1);
            rd_issue_d  = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (wr_valid && wr_ready_q) begin
          ram_ena_d   = 1'b1;
          ram_wena_d  = 1'b1;
          ram_addr_d  = next_addr_q;
          wdata_d     = wr_data;
          next_addr_d = next_addr_q + 1'b1;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == len_q) state_d = S_DONE;
        end
      end
      S_READ: begin
        ram_ena_d = 1'b1;
        if (cnt_q == len_q) begin
          // Last address already issued; keep it on the bus for one drain cycle.
          state_d = S_DRAIN;
        end else begin
          ram_addr_d  = next_addr_q;
          next_addr_d = next_addr_q + 1'b1;
          cnt_d       = cnt_q + 1'b1;
          rd_issue_d  = 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
    wr_ready_d  = (state_d == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      next_addr_q <= '0;
      wdata_q     <= '0;
      rd_issue_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      ram_ena_q   <= 1'b0;
      ram_wena_q  <= 1'b0;
      ram_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      next_addr_q <= next_addr_d;
      wdata_q     <= wdata_d;
      rd_issue_q  <= rd_issue_d;
      rd_pend_q   <= rd_pend_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      ram_ena_q   <= ram_ena_d;
      ram_wena_q  <= ram_wena_d;
      ram_addr_q  <= ram_addr_d;
    end
  end

  assign ram_data  = (ram_ena_q && ram_wena_q) ? wdata_q : {DATA_W{1'bz}};
  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_ena   = ram_ena_q;
  assign ram_wena  = ram_wena_q;
  assign ram_addr  = ram_addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: behavioural RAM on the shared bus, a per-burst cycle schedule
// derived from the burst rules, a read-data expected queue and a bus ownership monitor.
module tb_ram_burst_master;

  localparam int MAXC = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_write;
  logic [4:0]  cmd_addr;
  logic [5:0]  cmd_len;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        cmd_ready, wr_ready, rd_valid, busy, done;
  logic        ram_ena, ram_wena;
  logic [4:0]  ram_addr;
  logic [31:0] rd_data;
  wire  [31:0] ram_data;
  wire  [2:0]  dbg_state;

  ram_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_data(ram_data), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // behavioural RAM: commits writes at the edge, drives read word the cycle after the address
  logic [31:0] mem [32];
  logic        ram_drv = 1'b0;
  logic [31:0] ram_word = '0;
  assign ram_data = ram_drv ? ram_word : 32'bz;

  always @(posedge clk) begin
    if (ram_ena && ram_wena) mem[ram_addr] <= ram_data;
    ram_drv <= ram_ena && !ram_wena;
    if (ram_ena && !ram_wena) ram_word <= mem[ram_addr];
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [32];
  bit          mon_en = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endfunction

  // bus ownership monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_ena === 1'b1 && ram_wena === 1'b1) chk("bus_conflict", {31'b0, ram_drv}, 32'd0);
      else if (!ram_drv) chk("bus_z", {31'b0, (ram_data === 32'bz)}, 32'd1);
    end
  end

  // expected per-cycle schedule for one burst, indexed by T number
  bit          e_ena[MAXC], e_wena[MAXC], e_rdv[MAXC], e_done[MAXC], e_busy[MAXC];
  bit          e_wrr[MAXC], e_drv[MAXC];
  logic [4:0]  e_addr[MAXC];
  logic [31:0] e_bus[MAXC];
  int          e_idx[MAXC];
  logic [31:0] beat[64];

  task automatic run_cmd(input bit wr, input int a, input int n, input logic [31:0] gap,
                         input logic [31:0] base, input logic [31:0] step,
                         output int done_obs, output int done_exp);
    int k, acc, last;
    for (int i = 0; i < MAXC; i++) begin
      e_ena[i] = 0; e_wena[i] = 0; e_rdv[i] = 0; e_done[i] = 0; e_busy[i] = 0;
      e_wrr[i] = 0; e_drv[i] = 0; e_addr[i] = '0; e_bus[i] = '0; e_idx[i] = 0;
    end
    for (int i = 0; i < n; i++) beat[i] = base + step * i;
    if (wr) begin
      k = 1; acc = 0;
      while (acc < n) begin
        e_wrr[k] = 1; e_busy[k] = 1;
        e_drv[k] = (k < 32) ? !gap[k] : 1'b1;
        if (e_drv[k]) begin
          e_idx[k] = acc;
          e_ena[k+1] = 1; e_wena[k+1] = 1;
          e_addr[k+1] = 5'((a + acc) % 32);
          e_bus[k+1] = beat[acc];
          model_mem[(a + acc) % 32] = beat[acc];
          acc++;
        end
        k++;
      end
      last = k;
    end else if (n == 0) begin
      last = 1;
    end else begin
      for (int j = 1; j <= n + 1; j++) begin
        e_ena[j] = 1;
        e_addr[j] = 5'((a + ((j - 1 < n - 1) ? j - 1 : n - 1)) % 32);
      end
      for (int i = 0; i < n; i++) begin
        e_rdv[i+3] = 1;
        exp_q.push_back(model_mem[(a + i) % 32]);
      end
      last = n + 2;
    end
    for (int j = 1; j <= last; j++) e_busy[j] = 1;
    e_done[last] = 1;
    done_exp = last;
    done_obs = -1;

    // T0: offer the command
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = 5'(a); cmd_len = 6'(n); wr_valid = 1'b0;
    @(negedge clk);
    chk("t0_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("t0_busy", {31'b0, busy}, 32'd0);
    chk("t0_ena", {31'b0, ram_ena}, 32'd0);
    @(posedge clk); #1;

    for (k = 1; k <= last; k++) begin
      cmd_valid = 1'(($urandom_range(0, 1)));
      cmd_write = 1'($urandom); cmd_addr = 5'($urandom); cmd_len = 6'($urandom);
      if (e_wrr[k]) begin
        wr_valid = e_drv[k];
        wr_data  = e_drv[k] ? beat[e_idx[k]] : $urandom;
      end else begin
        wr_valid = 1'($urandom_range(0, 1));
        wr_data  = $urandom;
      end
      @(negedge clk);
      chk($sformatf("ram_ena@T%0d", k), {31'b0, ram_ena}, {31'b0, e_ena[k]});
      chk($sformatf("ram_wena@T%0d", k), {31'b0, ram_wena}, {31'b0, e_wena[k]});
      if (e_ena[k]) chk($sformatf("ram_addr@T%0d", k), {27'b0, ram_addr}, {27'b0, e_addr[k]});
      if (e_ena[k] && e_wena[k]) chk($sformatf("wr_bus@T%0d", k), ram_data, e_bus[k]);
      chk($sformatf("wr_ready@T%0d", k), {31'b0, wr_ready}, {31'b0, e_wrr[k]});
      chk($sformatf("busy@T%0d", k), {31'b0, busy}, {31'b0, e_busy[k]});
      chk($sformatf("cmd_ready@T%0d", k), {31'b0, cmd_ready}, {31'b0, !e_busy[k]});
      chk($sformatf("done@T%0d", k), {31'b0, done}, {31'b0, e_done[k]});
      chk($sformatf("rd_valid@T%0d", k), {31'b0, rd_valid}, {31'b0, e_rdv[k]});
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) chk($sformatf("rd_extra@T%0d", k), 32'd1, 32'd0);
        else chk($sformatf("rd_data@T%0d", k), rd_data, exp_q.pop_front());
      end
      if (done === 1'b1 && done_obs < 0) done_obs = k;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; wr_valid = 1'b0;
    chk("rd_words_missing", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    bit          wr;
    int          addr;
    int          len;
    logic [31:0] gap;
    logic [31:0] base;
    logic [31:0] step;
    int          exp_done;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int d_obs, d_exp;
    tbl[0] = '{1'b1,  2,  4, 32'h0,               32'h11,  32'h11, 5};
    tbl[1] = '{1'b0,  2,  4, 32'h0,               32'h0,   32'h0,  6};
    tbl[2] = '{1'b1, 30,  4, 32'h0,               32'hA0,  32'h1,  5};
    tbl[3] = '{1'b0, 30,  4, 32'h0,               32'h0,   32'h0,  6};
    tbl[4] = '{1'b1,  8,  3, 32'h14,              32'hC0,  32'h1,  6};
    tbl[5] = '{1'b0,  8,  3, 32'h0,               32'h0,   32'h0,  5};
    tbl[6] = '{1'b1, 12,  0, 32'h0,               32'h0,   32'h0,  1};
    tbl[7] = '{1'b0, 12,  0, 32'h0,               32'h0,   32'h0,  1};
    tbl[8] = '{1'b1,  3, 40, 32'h0,               32'h100, 32'h1,  41};
    tbl[9] = '{1'b0,  3, 40, 32'h0,               32'h0,   32'h0,  42};

    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      model_mem[i] = mem[i];
    end
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ram_ena", {31'b0, ram_ena}, 32'd0);
    chk("rst_ram_wena", {31'b0, ram_wena}, 32'd0);
    chk("rst_ram_addr", {27'b0, ram_addr}, 32'd0);
    chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_bus_z", {31'b0, (ram_data === 32'bz)}, 32'd1);
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // directed table, issued back to back
    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].gap, tbl[i].base, tbl[i].step, d_obs, d_exp);
      chk($sformatf("tbl%0d_done_cycle", i), d_obs, tbl[i].exp_done);
    end

    // reset in T3 of a read burst of 8
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd5; cmd_len = 6'd8;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_t3_ena", {31'b0, ram_ena}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
    for (int k = 4; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_ena@T%0d", k), {31'b0, ram_ena}, 32'd0);
      chk($sformatf("rst_mid_busy@T%0d", k), {31'b0, busy}, 32'd0);
      chk($sformatf("rst_mid_cmd_ready@T%0d", k), {31'b0, cmd_ready}, 32'd1);
      chk($sformatf("rst_mid_rd_valid@T%0d", k), {31'b0, rd_valid}, 32'd0);
      chk($sformatf("rst_mid_done@T%0d", k), {31'b0, done}, 32'd0);
      chk($sformatf("rst_mid_wr_ready@T%0d", k), {31'b0, wr_ready}, 32'd0);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    run_cmd(1'b0, 5, 1, 32'h0, 32'h0, 32'h0, d_obs, d_exp);
    chk("post_rst_read_done", d_obs, 32'd3);

    // randomized bursts against the schedule model
    for (int i = 0; i < 30; i++) begin
      automatic bit wr = 1'($urandom_range(0, 1));
      automatic int a = $urandom_range(0, 31);
      automatic int n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      automatic logic [31:0] gap = $urandom & $urandom;
      run_cmd(wr, a, n, gap, $urandom, $urandom, d_obs, d_exp);
      chk($sformatf("rand%0d_done_cycle", i), d_obs, d_exp);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
